// File: rtl/bmp_master_collector.sv
// Collects one frame of words from the arbiter master port into a FWFT FIFO and
// streams them out with an incrementing destination address.
module bmp_master_collector #(
    parameter int DATA_BUS_SIZE = 32,
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_BUS_SIZE-1:0] in_data,
    input  logic                     in_valid,
    input  logic                     in_cmplt,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        base_addr,
    output logic [DATA_BUS_SIZE-1:0] out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     frame_done,
    output logic [15:0]              frame_words
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [DATA_BUS_SIZE-1:0] mem_q [DEPTH];
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [15:0]              fw_q, fw_d;
    logic                     push, pop;

    assign in_ready    = (count_q != CW'(DEPTH)) && (state_q == IDLE || state_q == ACTIVE);
    assign out_valid   = (count_q != '0);
    assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_addr    = addr_q;
    assign frame_done  = (state_q == DONE);
    assign frame_words = fw_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = pop ? addr_q + ADDR_W'(1) : addr_q;
        fw_d    = fw_q;
        case (state_q)
            IDLE: begin
                // FIFO is empty in IDLE, so no pop competes with the base latch.
                if (push) begin
                    addr_d  = base_addr;
                    fw_d    = 16'd1;
                    state_d = in_cmplt ? DRAIN : ACTIVE;
                end else if (in_cmplt) begin
                    fw_d    = 16'd0;
                    state_d = DONE;
                end
            end
            ACTIVE: begin
                if (push && fw_q != 16'hFFFF) fw_d = fw_q + 16'd1;
                // Skip DRAIN when the FIFO empties on the completing edge itself.
                if (in_cmplt) state_d = (count_d == '0) ? DONE : DRAIN;
            end
            DRAIN: begin
                if (count_d == '0) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            addr_q   <= '0;
            fw_q     <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            fw_q     <= fw_d;
        end
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end
endmodule

// File: doc/bmp_master_collector.md
BMP_MASTER_COLLECTOR -- requirements
Module: bmp_master_collector

Interface
REQ-001 Parameter DATA_BUS_SIZE, default 32, SHALL set the word width of the input and output data paths.
REQ-002 Parameter DEPTH, default 16, SHALL set the number of buffer entries (power of two, at least 4).
REQ-003 Parameter ADDR_W, default 16, SHALL set the output address width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active-low.
REQ-006 in_data  input  DATA_BUS_SIZE  word from the arbiter master port.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_cmplt  input  1  one-cycle end-of-frame pulse from the arbiter.
REQ-009 in_ready  output  1  block accepts in_data; drives the arbiter's mstr0_ready.
REQ-010 base_addr  input  ADDR_W  start address for the frame; sampled when a frame opens.
REQ-011 out_data  output  DATA_BUS_SIZE  buffered word to the downstream memory writer.
REQ-012 out_addr  output  ADDR_W  destination address of out_data.
REQ-013 out_valid  output  1  out_data and out_addr are valid.
REQ-014 out_ready  input  1  downstream accepts the current word.
REQ-015 frame_done  output  1  one-cycle pulse after a frame is fully drained.
REQ-016 frame_words  output  16  number of words accepted in the current or last frame.

Function
REQ-017 Input transfer SHALL occur on a clock edge with in_valid=1 and in_ready=1; output transfer SHALL occur on an edge with out_valid=1 and out_ready=1.
REQ-018 Buffer SHALL be a DEPTH-entry circular FIFO with first-word-fall-through: out_data = head entry, out_valid = not empty.
REQ-019 Write and read pointers SHALL wrap from DEPTH-1 to 0; occupancy count SHALL span 0..DEPTH.
REQ-020 in_ready SHALL be 1 exactly when the FIFO is not full and state is IDLE or ACTIVE (combinational from registered state and count).
REQ-021 Full-FIFO bypass is not provided: when full, in_ready=0 even if out_ready=1.
REQ-022 A simultaneous read and write on a non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-023 Latency: a word accepted on edge N into an empty FIFO SHALL present out_valid=1 on the cycle after edge N.
REQ-024 State machine states SHALL be IDLE, ACTIVE, DRAIN and DONE.
REQ-025 IDLE->ACTIVE SHALL occur on the first accepted word, which also latches base_addr into the address counter and sets frame_words to 1.
REQ-026 In ACTIVE, each accepted word SHALL increment frame_words, saturating at 0xFFFF.
REQ-027 ACTIVE->DRAIN SHALL occur when in_cmplt=1; a word accepted on the same edge belongs to the frame.
REQ-028 In DRAIN, in_ready=0; DRAIN->DONE SHALL occur when the FIFO becomes empty, including on the edge that pops the last word.
REQ-029 DONE SHALL assert frame_done for exactly one cycle, then return to IDLE.
REQ-030 If in_cmplt=1 in IDLE, the block SHALL clear frame_words to 0 and go IDLE->DONE (empty frame).
REQ-031 If in_cmplt=1 in IDLE together with an accepted word, the block SHALL treat it as a one-word frame: latch base_addr, frame_words=1, go to DRAIN.
REQ-032 in_cmplt SHALL be ignored in DRAIN and DONE.
REQ-033 out_addr SHALL be the address counter, which increments by 1 per output transfer and wraps modulo 2^ADDR_W.
REQ-034 frame_words SHALL hold its final value from frame_done until the next frame opens.
REQ-035 in_valid and in_data SHALL be ignored while in_ready=0; no data is lost or duplicated.

Reset
REQ-036 While rst_n=0, state SHALL be IDLE, pointers and count 0, and outputs SHALL be out_valid=0, out_data=0, out_addr=0, frame_done=0, frame_words=0, in_ready=1.
REQ-037 Reset asserted mid-frame SHALL discard all buffered words immediately, without waiting for a clock edge, and no frame_done SHALL be generated for the aborted frame.

Verification
REQ-038 base_addr=0x0100, 3 words A,B,C, then in_cmplt, out_ready=1 -> outputs A,B,C at addresses 0x0100..0x0102, frame_done one cycle after C is popped, frame_words=3.
REQ-039 out_ready=0, 17 valid words -> 16 accepted, in_ready=0 after the 16th; raise out_ready -> 17th accepted only after the first pop, in order.
REQ-040 in_cmplt in IDLE with no data -> frame_done one cycle later, frame_words=0, out_valid stays 0.
REQ-041 base_addr=0xFFFE, 4 words -> out_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-042 rst_n pulled low with 5 words buffered in ACTIVE -> out_valid=0 and count=0 immediately; next frame restarts from base_addr.
REQ-043 in_cmplt on the same edge as the last data word, with out_ready toggling 1/0 -> that word is delivered, and frame_done follows the final pop.
